lock_requester: RTL and testbench
=================================

Name: lock_requester

Overview:
- Accelerator-side initiator for the hardware lock protocol served by the lock module in the HW runtime (HWR_LOCK_ID).
- Turns simple level/pulse lock and unlock requests from accelerator logic into single-beat CMD_LOCK_CODE / CMD_UNLOCK_CODE command words on an AXI-Stream master.
- Consumes ACK words from the lock module, retries after a reject, and presents a held grant to the accelerator.

Parameters:
- ACC_ID_BITS, 8, width of accelerator instance id driven on cmd_out_tid.
- BACKOFF_CYCLES, 16, idle cycles between an ACK_REJECT and the retransmitted lock command (minimum 1).
- MAX_RETRIES, 0, rejects tolerated before giving up; 0 means retry forever.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- acc_id  in  ACC_ID_BITS  this accelerator's id, copied to cmd_out_tid
- lock_req  in  1  request lock; sampled in IDLE only
- lock_id  in  8  lock id; captured with lock_req
- lock_gnt  out  1  high while lock is held
- lock_fail  out  1  one-cycle pulse when MAX_RETRIES is exhausted
- unlock_req  in  1  release held lock; sampled in LOCKED only
- busy  out  1  high in every state except IDLE
- proto_err  out  1  sticky; set on a malformed or unexpected ACK; cleared only by rst
- cmd_out_tdata  out  64  command word
- cmd_out_tvalid  out  1
- cmd_out_tready  in  1
- cmd_out_tid  out  ACC_ID_BITS
- cmd_out_tdest  out  3  constant HWR_LOCK_ID (3'h1)
- cmd_out_tlast  out  1  constant 1
- ack_in_tdata  in  64  ACK word
- ack_in_tvalid  in  1
- ack_in_tready  out  1

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0 except cmd_out_tdest=3'h1 and cmd_out_tlast=1. Captured id, backoff counter and retry counter are cleared. A reset in any state aborts the transaction immediately; no unlock is sent.
- Command word format:
  - [7:0] command code (0x04 lock, 0x06 unlock)
  - [15:8] captured lock id
  - [63:16] zero
- ACK word format:
  - [7:0] ACK code (0x00 REJECT, 0x01 OK, 0x02 FINAL)
  - [15:8] echoed lock id
  - remaining bits ignored
- IDLE: on lock_req=1, capture lock_id, clear the retry counter, go to SEND_LOCK. cmd_out_tvalid rises the next cycle.
- SEND_LOCK: drive tvalid=1 with the lock word. tdata and tid stay stable until the handshake (tvalid & tready). On handshake go to WAIT_ACK. tvalid never drops without a handshake.
- WAIT_ACK: ack_in_tready=1 here only (0 in every other state). On an ACK beat:
  - OK or FINAL with a matching id: go to LOCKED; lock_gnt=1 from the next cycle.
  - REJECT with a matching id: increment the retry counter.
    - If MAX_RETRIES!=0 and the count equals MAX_RETRIES: pulse lock_fail and go to IDLE.
    - Otherwise load the backoff counter with BACKOFF_CYCLES-1 and go to BACKOFF.
  - Id mismatch or unknown code: word consumed and dropped, proto_err set, stay in WAIT_ACK.
- BACKOFF: decrement each cycle; at 0 go to SEND_LOCK. The retransmit's tvalid rises exactly BACKOFF_CYCLES+1 cycles after the REJECT handshake cycle.
- LOCKED: lock_gnt=1. lock_req is ignored. On unlock_req=1, lock_gnt drops the next cycle and the block goes to SEND_UNLOCK.
- SEND_UNLOCK: drive the unlock word. On handshake go to IDLE. Unlock is fire-and-forget; no ACK is expected.
- An ACK beat arriving outside WAIT_ACK is not accepted (tready=0) and is left pending on the bus.
- unlock_req outside LOCKED is ignored. lock_req outside IDLE is ignored.
- A lock_req asserted in the same cycle SEND_UNLOCK completes is ignored. It must be re-sampled in IDLE on a later cycle.
- Minimum lock round trip, with tready=1 and the ACK in the cycle after the send: req at cycle 0, tvalid at 1, ACK at 2, lock_gnt at 3.

Test Plan:
- Basic grant: lock_req with lock_id=0x2A, acc_id=0x05, tready=1, ACK 0x...2A01 one cycle after send -> exactly one beat tdata=0x0000_0000_0000_2A04, tid=0x05, tdest=1, tlast=1; lock_gnt high 3 cycles after req.
- Backpressure: cmd_out_tready low for 7 cycles -> tvalid held and tdata unchanged for all 7 cycles; one handshake only.
- Reject/retry: REJECT (0x...2A00) then OK, BACKOFF_CYCLES=16 -> second lock beat has tvalid rising 17 cycles after the REJECT handshake; lock_gnt then asserts.
- Give-up: MAX_RETRIES=3, three REJECTs -> lock_fail pulses for exactly 1 cycle after the third; busy=0; exactly 3 lock beats sent.
- Unlock: in LOCKED, pulse unlock_req -> lock_gnt low the next cycle; one beat tdata=0x...2A06; no ACK consumed; returns to IDLE.
- Error and reset: ACK with id 0x2B while waiting on 0x2A -> dropped, proto_err=1, still waiting. Assert rst mid-SEND_LOCK -> tvalid=0, lock_gnt=0, proto_err=0 asynchronously.

Source files
------------

// File: rtl/lock_requester.sv
// lock_requester: accelerator-side initiator for the hardware lock protocol.
// Sends lock/unlock command beats, consumes ACKs, retries with backoff, holds grant.
// Ports:
//   clk, rst           clock, async active-high reset
//   acc_id             accelerator id, sent on cmd_out_tid
//   lock_req/lock_id   lock request (sampled in IDLE) and lock id
//   unlock_req         release request (sampled in LOCKED)
//   lock_gnt           high while the lock is held
//   lock_fail          one-cycle pulse when retries are exhausted
//   busy               high whenever not IDLE
//   proto_err          sticky malformed/unexpected ACK flag
//   cmd_out_*          AXI-Stream command master
//   ack_in_*           AXI-Stream ACK slave
module lock_requester #(
  parameter int ACC_ID_BITS    = 8,
  parameter int BACKOFF_CYCLES = 16,
  parameter int MAX_RETRIES    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_ID_BITS-1:0] acc_id,
  input  logic                   lock_req,
  input  logic [7:0]             lock_id,
  output logic                   lock_gnt,
  output logic                   lock_fail,
  input  logic                   unlock_req,
  output logic                   busy,
  output logic                   proto_err,
  output logic [63:0]            cmd_out_tdata,
  output logic                   cmd_out_tvalid,
  input  logic                   cmd_out_tready,
  output logic [ACC_ID_BITS-1:0] cmd_out_tid,
  output logic [2:0]             cmd_out_tdest,
  output logic                   cmd_out_tlast,
  input  logic [63:0]            ack_in_tdata,
  input  logic                   ack_in_tvalid,
  output logic                   ack_in_tready
);

  localparam logic [2:0] HWR_LOCK_ID     = 3'h1;
  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_REJECT      = 8'h00;
  localparam logic [7:0] ACK_OK          = 8'h01;
  localparam logic [7:0] ACK_FINAL       = 8'h02;

  localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_LOCK,
    S_WAIT_ACK,
    S_BACKOFF,
    S_LOCKED,
    S_SEND_UNLOCK
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             id_q, id_d;
  logic [ACC_ID_BITS-1:0] tid_q, tid_d;
  logic [BW-1:0]          boff_q, boff_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic                   fail_q, fail_d;
  logic                   err_q, err_d;

  logic [7:0]    ack_code;
  logic          id_match;
  logic [RW-1:0] retry_inc;
  logic          unused_ack;

  assign ack_code   = ack_in_tdata[7:0];
  assign id_match   = (ack_in_tdata[15:8] == id_q);
  assign retry_inc  = retry_q + 1'b1;
  assign unused_ack = ^ack_in_tdata[63:16];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      tid_q   <= '0;
      boff_q  <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      tid_q   <= tid_d;
      boff_q  <= boff_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    tid_d   = tid_q;
    boff_d  = boff_q;
    retry_d = retry_q;
    fail_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (lock_req) begin
          id_d    = lock_id;
          tid_d   = acc_id;
          retry_d = '0;
          state_d = S_SEND_LOCK;
        end
      end
      S_SEND_LOCK: begin
        if (cmd_out_tready) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_in_tvalid) begin
          if (id_match && (ack_code == ACK_OK ||
                           ack_code == ACK_FINAL)) begin
            state_d = S_LOCKED;
          end else if (id_match && ack_code == ACK_REJECT) begin
            retry_d = retry_inc;
            if (MAX_RETRIES != 0 &&
                retry_inc == RW'(MAX_RETRIES)) begin
              fail_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              boff_d  = BW'(BACKOFF_CYCLES - 1);
              state_d = S_BACKOFF;
            end
          end else begin
            // Bad id or unknown code: swallow the beat, keep waiting
            err_d = 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        if (boff_q == '0) state_d = S_SEND_LOCK;
        else boff_d = boff_q - 1'b1;
      end
      S_LOCKED: begin
        if (unlock_req) state_d = S_SEND_UNLOCK;
      end
      S_SEND_UNLOCK: begin
        if (cmd_out_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_out_tvalid = 1'b0;
    cmd_out_tdata  = '0;
    lock_gnt       = 1'b0;
    ack_in_tready  = 1'b0;
    busy           = (state_q != S_IDLE);
    unique case (state_q)
      S_SEND_LOCK: begin
        cmd_out_tvalid = 1'b1;
        cmd_out_tdata  = {48'h0, id_q, CMD_LOCK_CODE};
      end
      S_SEND_UNLOCK: begin
        cmd_out_tvalid = 1'b1;
        cmd_out_tdata  = {48'h0, id_q, CMD_UNLOCK_CODE};
      end
      S_WAIT_ACK: ack_in_tready = 1'b1;
      S_LOCKED:   lock_gnt = 1'b1;
      default: ;
    endcase
  end

  assign cmd_out_tid   = tid_q;
  assign cmd_out_tdest = HWR_LOCK_ID;
  assign cmd_out_tlast = 1'b1;
  assign lock_fail     = fail_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_lock_requester.sv
// tb_lock_requester: directed + randomized bench for lock_requester.
// A protocol-level model predicts every output each cycle.
module tb_lock_requester;

  localparam int AIB  = 8;
  localparam int BOFF = 16;
  localparam int MAXR = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [AIB-1:0] acc_id;
  logic           lock_req;
  logic [7:0]     lock_id;
  logic           lock_gnt;
  logic           lock_fail;
  logic           unlock_req;
  logic           busy;
  logic           proto_err;
  logic [63:0]    cmd_out_tdata;
  logic           cmd_out_tvalid;
  logic           cmd_out_tready;
  logic [AIB-1:0] cmd_out_tid;
  logic [2:0]     cmd_out_tdest;
  logic           cmd_out_tlast;
  logic [63:0]    ack_in_tdata;
  logic           ack_in_tvalid;
  logic           ack_in_tready;

  always #5 clk = ~clk;

  lock_requester #(
    .ACC_ID_BITS   (AIB),
    .BACKOFF_CYCLES(BOFF),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .acc_id        (acc_id),
    .lock_req      (lock_req),
    .lock_id       (lock_id),
    .lock_gnt      (lock_gnt),
    .lock_fail     (lock_fail),
    .unlock_req    (unlock_req),
    .busy          (busy),
    .proto_err     (proto_err),
    .cmd_out_tdata (cmd_out_tdata),
    .cmd_out_tvalid(cmd_out_tvalid),
    .cmd_out_tready(cmd_out_tready),
    .cmd_out_tid   (cmd_out_tid),
    .cmd_out_tdest (cmd_out_tdest),
    .cmd_out_tlast (cmd_out_tlast),
    .ack_in_tdata  (ack_in_tdata),
    .ack_in_tvalid (ack_in_tvalid),
    .ack_in_tready (ack_in_tready)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Protocol-level model: phase of the lock transaction, backoff
  // expressed as the absolute cycle on which the resend appears.
  typedef enum int {
    M_IDLE, M_LOCKREQ, M_WAIT, M_PAUSE, M_HELD, M_RELEASE
  } mphase_e;

  mphase_e    ph          = M_IDLE;
  int         cyc         = 0;
  int         resume_at   = 0;
  int         m_rejects   = 0;
  logic [7:0] m_id        = 8'h00;
  logic       m_fail      = 1'b0;
  logic       m_err       = 1'b0;
  logic       m_ack_taken = 1'b0;
  logic       chk_en      = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph          <= M_IDLE;
      m_id        <= 8'h00;
      m_fail      <= 1'b0;
      m_err       <= 1'b0;
      m_rejects   <= 0;
      m_ack_taken <= 1'b0;
    end else begin
      m_fail      <= 1'b0;
      m_ack_taken <= 1'b0;
      case (ph)
        M_IDLE: if (lock_req) begin
          ph        <= M_LOCKREQ;
          m_id      <= lock_id;
          m_rejects <= 0;
        end
        M_LOCKREQ: if (cmd_out_tready) ph <= M_WAIT;
        M_WAIT: if (ack_in_tvalid) begin
          m_ack_taken <= 1'b1;
          if (ack_in_tdata[15:8] != m_id) m_err <= 1'b1;
          else if (ack_in_tdata[7:0] == 8'h01 ||
                   ack_in_tdata[7:0] == 8'h02) ph <= M_HELD;
          else if (ack_in_tdata[7:0] == 8'h00) begin
            m_rejects <= m_rejects + 1;
            if (MAXR != 0 && m_rejects + 1 == MAXR) begin
              m_fail <= 1'b1;
              ph     <= M_IDLE;
            end else begin
              resume_at <= cyc + BOFF + 1;
              ph        <= M_PAUSE;
            end
          end else m_err <= 1'b1;
        end
        M_PAUSE: if (cyc + 1 == resume_at) ph <= M_LOCKREQ;
        M_HELD: if (unlock_req) ph <= M_RELEASE;
        M_RELEASE: if (cmd_out_tready) ph <= M_IDLE;
        default: ph <= M_IDLE;
      endcase
      cyc <= cyc + 1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic       ev;
      logic [7:0] code;
      ev   = (ph == M_LOCKREQ) || (ph == M_RELEASE);
      code = (ph == M_LOCKREQ) ? 8'h04 : 8'h06;
      chk("m_tvalid", cmd_out_tvalid, ev);
      chk("m_gnt", lock_gnt, ph == M_HELD);
      chk("m_busy", busy, ph != M_IDLE);
      chk("m_ack_tready", ack_in_tready, ph == M_WAIT);
      chk("m_fail", lock_fail, m_fail);
      chk("m_err", proto_err, m_err);
      chk("m_tdest", cmd_out_tdest, 3'h1);
      chk("m_tlast", cmd_out_tlast, 1'b1);
      if (ev) begin
        chk("m_tdata", cmd_out_tdata, {48'h0, m_id, code});
        chk("m_tid", cmd_out_tid, acc_id);
      end
    end
  end

  // Beat / ACK monitors
  int beats = 0;
  int acks  = 0;
  always @(posedge clk) begin
    if (!rst && cmd_out_tvalid && cmd_out_tready) beats <= beats + 1;
    if (!rst && ack_in_tvalid && ack_in_tready) acks <= acks + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!cmd_out_tvalid && n < 64) begin
      tick();
      n++;
    end
    if (!cmd_out_tvalid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic send_ack(input logic [15:0] w);
    ack_in_tvalid = 1'b1;
    ack_in_tdata  = {48'hDEAD_BEEF_0000, w};
    tick();
    ack_in_tvalid = 1'b0;
  endtask

  int n;
  int b0;
  int a0;

  initial begin
    logic [7:0] aid;
    logic [7:0] acode;
    int         r;
    rst            = 1'b1;
    acc_id         = 8'h05;
    lock_req       = 1'b0;
    lock_id        = 8'h00;
    unlock_req     = 1'b0;
    cmd_out_tready = 1'b0;
    ack_in_tdata   = '0;
    ack_in_tvalid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", cmd_out_tvalid, 1'b0);
    chk("rst_tdata", cmd_out_tdata, 64'h0);
    chk("rst_tdest", cmd_out_tdest, 3'h1);
    chk("rst_tlast", cmd_out_tlast, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", lock_gnt, 1'b0);
    chk("rst_ack_tready", ack_in_tready, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Basic grant: req cycle 0, tvalid 1, ACK 2, gnt 3
    cmd_out_tready = 1'b1;
    lock_id        = 8'h2A;
    lock_req       = 1'b1;
    tick();
    lock_req = 1'b0;
    lock_id  = 8'h77;
    chk("grant_tvalid", cmd_out_tvalid, 1'b1);
    chk("grant_tdata", cmd_out_tdata, 64'h2A04);
    chk("grant_tid", cmd_out_tid, 8'h05);
    chk("grant_gnt_early", lock_gnt, 1'b0);
    tick();
    chk("grant_ack_tready", ack_in_tready, 1'b1);
    chk("grant_one_beat", beats, 1);
    send_ack(16'h2A01);
    chk("grant_gnt", lock_gnt, 1'b1);

    // Unlock while an ACK is pending on the bus
    a0            = acks;
    ack_in_tvalid = 1'b1;
    ack_in_tdata  = 64'h2A01;
    unlock_req    = 1'b1;
    tick();
    unlock_req = 1'b0;
    chk("unlock_gnt", lock_gnt, 1'b0);
    chk("unlock_tdata", cmd_out_tdata, 64'h2A06);
    chk("unlock_tready", ack_in_tready, 1'b0);
    tick();
    chk("unlock_idle", busy, 1'b0);
    chk("unlock_no_ack", acks - a0, 0);
    ack_in_tvalid = 1'b0;

    // Backpressure for 7 cycles
    b0             = beats;
    cmd_out_tready = 1'b0;
    lock_id        = 8'h2A;
    lock_req       = 1'b1;
    tick();
    lock_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("bp_tvalid", cmd_out_tvalid, 1'b1);
      chk("bp_tdata", cmd_out_tdata, 64'h2A04);
      tick();
    end
    cmd_out_tready = 1'b1;
    tick();
    chk("bp_one_beat", beats - b0, 1);

    // Reject then FINAL
    send_ack(16'h2A00);
    wait_valid(n);
    chk("backoff_gap", n, BOFF + 1);
    tick();
    send_ack(16'h2A02);
    chk("retry_gnt", lock_gnt, 1'b1);

    // lock_req during the unlock handshake is dropped
    unlock_req = 1'b1;
    tick();
    unlock_req = 1'b0;
    lock_req   = 1'b1;
    tick();
    lock_req = 1'b0;
    chk("req_in_unlock", busy, 1'b0);
    tick();
    chk("req_in_unlock2", busy, 1'b0);

    // Id mismatch and unknown code
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    tick();
    send_ack(16'h2B01);
    chk("err_flag", proto_err, 1'b1);
    chk("err_waiting", ack_in_tready, 1'b1);
    send_ack(16'h2A07);
    chk("err_code_waiting", ack_in_tready, 1'b1);
    send_ack(16'h2A01);
    chk("err_then_gnt", lock_gnt, 1'b1);
    unlock_req = 1'b1;
    tick();
    unlock_req = 1'b0;
    tick();

    // Give-up after MAXR rejects
    b0       = beats;
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    for (int k = 0; k < MAXR; k++) begin
      tick();
      send_ack(16'h2A00);
      if (k < MAXR - 1) wait_valid(n);
    end
    chk("fail_pulse", lock_fail, 1'b1);
    chk("fail_idle", busy, 1'b0);
    chk("fail_beats", beats - b0, MAXR);
    tick();
    chk("fail_pulse_end", lock_fail, 1'b0);

    // Async reset in the middle of a stalled send
    cmd_out_tready = 1'b0;
    lock_req       = 1'b1;
    tick();
    lock_req = 1'b0;
    chk("pre_rst_tvalid", cmd_out_tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", cmd_out_tvalid, 1'b0);
    chk("arst_gnt", lock_gnt, 1'b0);
    chk("arst_err", proto_err, 1'b0);
    chk("arst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;

    // Randomized traffic
    acc_id = 8'h5C;
    for (int i = 0; i < 3000; i++) begin
      if (ack_in_tvalid && m_ack_taken) ack_in_tvalid = 1'b0;
      if (!ack_in_tvalid && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) acode = 8'h01;
        else if (r == 4) acode = 8'h02;
        else if (r < 8) acode = 8'h00;
        else acode = 8'($urandom_range(3, 255));
        aid = ($urandom_range(0, 7) == 0) ? (m_id ^ 8'h80) : m_id;
        ack_in_tdata  = {$urandom(), $urandom()};
        ack_in_tdata[15:0] = {aid, acode};
        ack_in_tvalid = 1'b1;
      end
      cmd_out_tready = ($urandom_range(0, 3) != 0);
      lock_req       = ($urandom_range(0, 3) == 0);
      lock_id        = 8'($urandom_range(0, 255));
      unlock_req     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
